// File: rtl/gen_mode_pipe.sv
// Valid/ready pipeline of STAGES registers with one elaboration-time transform on the input side.
// Latency STAGES cycles (0 = combinational bypass); empty stages fill even when downstream stalls.
module gen_mode_pipe #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2,
   parameter int MODE   = 0,
   parameter int SHIFT  = 1,
   parameter int OFFSET = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [15:0]      xfer_cnt
);

   logic [WIDTH-1:0] f_dat;
   logic             out_fire;

   generate
      if (MODE == 0) begin : g_pass
         assign f_dat = in_data;
      end else if (MODE == 1) begin : g_inv
         assign f_dat = ~in_data;
      end else if (MODE == 2) begin : g_shl
         assign f_dat = in_data << SHIFT;
      end else if (MODE == 3) begin : g_sat
         localparam logic [WIDTH-1:0] OFS = OFFSET[WIDTH-1:0];
         logic [WIDTH:0] sum;
         assign sum   = {1'b0, in_data} + {1'b0, OFS};
         assign f_dat = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
      end else begin : g_zero
         logic unused_in;
         assign unused_in = ^in_data;
         assign f_dat     = '0;
      end
   endgenerate

   generate
      if (STAGES == 0) begin : g_bypass
         assign out_valid = in_valid & rst_n;
         assign out_data  = f_dat;
         assign in_ready  = out_ready & ~flush & rst_n;
      end else begin : g_pipe
         logic [STAGES-1:0] vld;
         logic [WIDTH-1:0]  dat [STAGES];
         logic [STAGES-1:0] load;
         logic [STAGES-1:0] up_vld;
         logic [WIDTH-1:0]  up_dat [STAGES];
         logic              rdy;

         // A stage loads when empty or when everything downstream of it can move.
         always_comb begin
            load = '0;
            rdy  = out_ready;
            for (int i = STAGES - 1; i >= 0; i--) begin
               load[i] = ~vld[i] | rdy;
               rdy     = load[i];
            end
         end

         always_comb begin
            up_vld    = '0;
            up_dat    = '{default: '0};
            up_vld[0] = in_valid;
            up_dat[0] = f_dat;
            for (int i = 1; i < STAGES; i++) begin
               up_vld[i] = vld[i-1];
               up_dat[i] = dat[i-1];
            end
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               vld <= '0;
               for (int i = 0; i < STAGES; i++) begin
                  dat[i] <= '0;
               end
            end else if (flush) begin
               vld <= '0;
            end else begin
               for (int i = 0; i < STAGES; i++) begin
                  if (load[i]) begin
                     vld[i] <= up_vld[i];
                     dat[i] <= up_dat[i];
                  end
               end
            end
         end

         assign in_ready  = load[0] & ~flush & rst_n;
         assign out_valid = vld[STAGES-1];
         assign out_data  = dat[STAGES-1];
      end
   endgenerate

   assign out_fire = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         xfer_cnt <= '0;
      end else if (out_fire) begin
         xfer_cnt <= xfer_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_gen_mode_pipe.sv
// Five differently configured pipes share one randomized stream; each is checked every cycle
// against a slot-occupancy reference model, plus directed scenarios with literal expectations.
module tb_gen_mode_pipe;
   localparam int NI = 5;

   logic clk;
   logic rst_n, flush, in_valid, out_ready;
   logic [7:0] in_data;
   logic [NI-1:0] ir, ov;
   logic [NI-1:0][7:0] od;
   logic [NI-1:0][15:0] xc;

   int n_chk, n_err;

   gen_mode_pipe #(.WIDTH(8), .STAGES(2), .MODE(0), .SHIFT(1), .OFFSET(1)) u_d0 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .in_ready(ir[0]), .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready), .xfer_cnt(xc[0]));
   gen_mode_pipe #(.WIDTH(8), .STAGES(3), .MODE(3), .SHIFT(1), .OFFSET(16)) u_d1 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .in_ready(ir[1]), .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready), .xfer_cnt(xc[1]));
   gen_mode_pipe #(.WIDTH(8), .STAGES(1), .MODE(2), .SHIFT(1), .OFFSET(1)) u_d2 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .in_ready(ir[2]), .out_valid(ov[2]), .out_data(od[2]), .out_ready(out_ready), .xfer_cnt(xc[2]));
   gen_mode_pipe #(.WIDTH(8), .STAGES(4), .MODE(1), .SHIFT(1), .OFFSET(1)) u_d3 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .in_ready(ir[3]), .out_valid(ov[3]), .out_data(od[3]), .out_ready(out_ready), .xfer_cnt(xc[3]));
   gen_mode_pipe #(.WIDTH(8), .STAGES(0), .MODE(7), .SHIFT(1), .OFFSET(1)) u_d4 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .in_ready(ir[4]), .out_valid(ov[4]), .out_data(od[4]), .out_ready(out_ready), .xfer_cnt(xc[4]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: per instance, a row of slots (index STAGES-1 faces the output).
   int          nst [NI] = '{2, 3, 1, 4, 0};
   logic        mv  [NI][4];
   logic [7:0]  md  [NI][4];
   logic [15:0] mc  [NI];
   logic [7:0]  q0[$], q1[$], q2[$], q3[$];
   logic [NI-1:0] last_acc;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ref_f(input int k, input logic [7:0] x);
      int s;
      case (k)
         0: return x;
         1: begin
            s = int'(x) + 16;
            return (s > 255) ? 8'hFF : 8'(s);
         end
         2: return 8'((int'(x) * 2) % 256);
         3: return 8'(255 - int'(x));
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic exp_ready(input int k);
      int occ;
      occ = 0;
      if (nst[k] == 0) return rst_n && out_ready && !flush;
      for (int i = 0; i < nst[k]; i++) occ += int'(mv[k][i]);
      return rst_n && !flush && (occ < nst[k] || out_ready);
   endfunction

   task automatic model_clear();
      for (int k = 0; k < NI; k++) begin
         mc[k] = 16'h0;
         for (int i = 0; i < 4; i++) begin
            mv[k][i] = 1'b0;
            md[k][i] = 8'h00;
         end
      end
   endtask

   task automatic clear_queues();
      q0.delete(); q1.delete(); q2.delete(); q3.delete();
   endtask

   // One clock: compare at the falling edge, advance the model, return just after the rising edge.
   task automatic cyc();
      logic eo, er, pop, acc;
      logic [7:0] eod;
      int n, h;
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         n  = nst[k];
         er = exp_ready(k);
         if (n == 0) begin
            eo  = in_valid && rst_n;
            eod = ref_f(k, in_data);
         end else begin
            eo  = mv[k][n-1];
            eod = md[k][n-1];
         end
         check_eq($sformatf("d%0d in_ready", k), 32'(ir[k]), 32'(er));
         check_eq($sformatf("d%0d out_valid", k), 32'(ov[k]), 32'(eo));
         if (eo) check_eq($sformatf("d%0d out_data", k), 32'(od[k]), 32'(eod));
         check_eq($sformatf("d%0d xfer_cnt", k), 32'(xc[k]), 32'(mc[k]));
         last_acc[k] = ir[k] && in_valid;
         if (ov[k] && out_ready) begin
            case (k)
               0: q0.push_back(od[k]);
               1: q1.push_back(od[k]);
               2: q2.push_back(od[k]);
               3: q3.push_back(od[k]);
               default: ;
            endcase
         end
         pop = eo && out_ready;
         acc = in_valid && er;
         if (!rst_n) begin
            mc[k] = 16'h0;
            for (int i = 0; i < 4; i++) mv[k][i] = 1'b0;
         end else begin
            if (pop) mc[k] += 16'd1;
            if (n > 0) begin
               if (flush) begin
                  for (int i = 0; i < 4; i++) mv[k][i] = 1'b0;
               end else begin
                  // Everything below the highest free slot moves one place forward.
                  h = pop ? n - 1 : -1;
                  if (!pop) for (int i = 0; i < n; i++) if (!mv[k][i]) h = i;
                  for (int i = h; i > 0; i--) begin
                     mv[k][i] = mv[k][i-1];
                     md[k][i] = md[k][i-1];
                  end
                  if (h >= 0) mv[k][0] = 1'b0;
                  if (acc) begin
                     mv[k][0] = 1'b1;
                     md[k][0] = ref_f(k, in_data);
                  end
               end
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      clear_queues();
   endtask

   initial begin
      int widx;
      n_chk = 0;
      n_err = 0;
      last_acc = '0;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
      model_clear();
      @(posedge clk);
      #1;
      in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
      cyc();
      for (int k = 0; k < NI; k++) begin
         check_eq($sformatf("rst d%0d out_valid", k), 32'(ov[k]), 32'h0);
         check_eq($sformatf("rst d%0d out_data", k), 32'(od[k]), 32'h0);
         check_eq($sformatf("rst d%0d xfer_cnt", k), 32'(xc[k]), 32'h0);
         check_eq($sformatf("rst d%0d in_ready", k), 32'(ir[k]), 32'h0);
      end

      // Basic latency and order through the 2-stage pass-through pipe.
      rst_n = 1'b1; clear_queues();
      in_data = 8'h01; cyc();
      check_eq("lat d0 ov@1", 32'(ov[0]), 32'h0);
      in_data = 8'h02; cyc();
      check_eq("lat d0 ov@2", 32'(ov[0]), 32'h1);
      check_eq("lat d0 od@2", 32'(od[0]), 32'h01);
      in_data = 8'h03; cyc();
      check_eq("lat d0 od@3", 32'(od[0]), 32'h02);
      in_valid = 1'b0; cyc();
      check_eq("lat d0 od@4", 32'(od[0]), 32'h03);
      cyc();
      check_eq("lat d0 ov@5", 32'(ov[0]), 32'h0);
      check_eq("lat d0 cnt", 32'(xc[0]), 32'h3);

      // Transform values.
      do_reset();
      out_ready = 1'b1; in_valid = 1'b1;
      in_data = 8'hE0; cyc();
      in_data = 8'hF5; cyc();
      in_data = 8'h81; cyc();
      in_data = 8'h0F; cyc();
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) cyc();
      check_eq("xf d1 count", 32'(q1.size()), 32'h4);
      check_eq("xf sat E0", 32'(q1[0]), 32'hF0);
      check_eq("xf sat F5", 32'(q1[1]), 32'hFF);
      check_eq("xf shl 81", 32'(q2[2]), 32'h02);
      check_eq("xf inv 0F", 32'(q3[3]), 32'hF0);

      // Backpressure on the 3-stage pipe: exactly 3 words fit, then all 5 drain in order.
      do_reset();
      out_ready = 1'b0; widx = 0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 8'(widx + 1);
         cyc();
         if (last_acc[1]) widx++;
      end
      check_eq("bp d1 accepted", 32'(widx), 32'h3);
      check_eq("bp d1 in_ready", 32'(ir[1]), 32'h0);
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_valid = (widx < 5); in_data = 8'(widx + 1);
         cyc();
         if (last_acc[1]) widx++;
      end
      check_eq("bp d1 out count", 32'(q1.size()), 32'h5);
      for (int i = 0; i < 5; i++)
         check_eq($sformatf("bp d1 word%0d", i), 32'(q1[i]), 32'(8'h11 + i));

      // Flush of a full pipe drops held words and the word offered alongside it.
      do_reset();
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 8'hAA; cyc();
      in_data = 8'hBB; cyc();
      in_data = 8'hCC; flush = 1'b1; cyc();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      check_eq("fl d0 out_valid", 32'(ov[0]), 32'h0);
      check_eq("fl d0 in_ready", 32'(ir[0]), 32'h1);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) cyc();
      check_eq("fl d0 no output", 32'(q0.size()), 32'h0);

      // Transfer counter wrap, then reset mid-stream.
      do_reset();
      out_ready = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 65536; i++) begin
         in_data = 8'($urandom);
         cyc();
      end
      check_eq("wrap d0 fffe", 32'(xc[0]), 32'hFFFE);
      cyc();
      cyc();
      check_eq("wrap d0 zero", 32'(xc[0]), 32'h0);
      check_eq("wrap d4 two", 32'(xc[4]), 32'h2);
      rst_n = 1'b0;
      cyc();
      check_eq("mrst d0 ov", 32'(ov[0]), 32'h0);
      check_eq("mrst d0 od", 32'(od[0]), 32'h0);
      check_eq("mrst d0 cnt", 32'(xc[0]), 32'h0);
      check_eq("mrst d0 in_ready", 32'(ir[0]), 32'h0);
      check_eq("mrst d4 ov", 32'(ov[4]), 32'h0);
      rst_n = 1'b1;

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 8'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 29) == 0);
         rst_n     = ($urandom_range(0, 79) != 0);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/gen_mode_pipe.md
GEN_MODE_PIPE -- requirements
Module: gen_mode_pipe

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits, legal range 1..32.
REQ-002 Parameter STAGES, default 2: number of register stages, legal range 0..4; 0 = combinational bypass.
REQ-003 Parameter MODE, default 0: transform select; 0 pass, 1 invert, 2 shift-left, 3 saturating add, any other value = constant zero.
REQ-004 Parameter SHIFT, default 1: left-shift amount for MODE 2, legal range 0..WIDTH-1.
REQ-005 Parameter OFFSET, default 1: unsigned addend for MODE 3, truncated to WIDTH bits.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 flush  input  1  synchronous pipeline clear.
REQ-009 in_valid  input  1  input word present.
REQ-010 in_data  input  WIDTH  input word.
REQ-011 in_ready  output  1  block accepts the input word this cycle.
REQ-012 out_valid  output  1  output word present.
REQ-013 out_data  output  WIDTH  transformed word.
REQ-014 out_ready  input  1  downstream accepts the output word.
REQ-015 xfer_cnt  output  16  count of completed output transfers.

Function
REQ-016 The transform f() shall be selected at elaboration by MODE via generate-if; exactly one transform exists in the netlist.
REQ-017 f() shall be: MODE 0 f(x)=x; MODE 1 f(x)=~x; MODE 2 f(x)=(x<<SHIFT) truncated to WIDTH; MODE 3 f(x)=min(x+OFFSET, 2^WIDTH-1) with the sum computed in WIDTH+1 bits; other MODE values f(x)=0.
REQ-018 f() shall be applied once, on the input side, before stage 0; later stages shall copy data unchanged.
REQ-019 Input transfer occurs in a cycle when in_valid and in_ready are both 1; output transfer when out_valid and out_ready are both 1.
REQ-020 With STAGES>0, each stage i shall hold a valid bit and a WIDTH data register.
REQ-021 Stage i shall load from its upstream (stage i-1, or the input for i=0) when its valid bit is 0 or its own contents advance this cycle; the last stage advances on out_ready.
REQ-022 Bubbles shall collapse: an empty stage shall accept upstream data even while downstream stages are stalled.
REQ-023 in_ready shall equal (stage 0 empty or stage 0 advancing) and not flush and rst_n, combinationally.
REQ-024 out_valid and out_data shall be driven directly from the last stage's registers.
REQ-025 Latency with out_ready held at 1 shall be exactly STAGES cycles from input transfer to out_valid; full throughput shall be one word per cycle.
REQ-026 Word order shall be preserved; no word shall be duplicated or dropped except by flush or reset.
REQ-027 With STAGES=0: out_valid=in_valid, out_data=f(in_data), in_ready=out_ready and not flush, all combinational.
REQ-028 flush=1 shall clear all valid bits at the next edge; a word offered on in_valid in a flush cycle is not accepted; an output transfer in a flush cycle still counts.
REQ-029 xfer_cnt shall increment by 1 on each output transfer and wrap from 16'hFFFF to 16'h0000.
REQ-030 A data register shall hold its value when its stage does not load.

Reset
REQ-031 While rst_n=0 at a rising edge: all valid bits 0, all data registers 0, xfer_cnt 0.
REQ-032 While rst_n=0, in_ready shall be 0; with STAGES=0, out_valid shall still be 0 while rst_n=0.
REQ-033 Reset asserted mid-stream shall discard all in-flight words; the first word accepted after release is the first word output.
REQ-034 Reset shall take priority over flush and over any transfer in the same cycle.

Verification
REQ-035 MODE=0, STAGES=2, out_ready=1, inputs 8'h01,8'h02,8'h03 back-to-back -> outputs 8'h01,8'h02,8'h03 on cycles 2,3,4 after first accept; xfer_cnt=3.
REQ-036 MODE=3, OFFSET=8'h10, inputs 8'hE0, 8'hF5 -> outputs 8'hF0, 8'hFF (saturated); MODE=2, SHIFT=1, input 8'h81 -> 8'h02; MODE=1, input 8'h0F -> 8'hF0.
REQ-037 STAGES=3, out_ready=0, stream 5 words -> exactly 3 accepted, then in_ready=0; raise out_ready -> all 5 emerge in order, no duplicates.
REQ-038 STAGES=2, pipeline full, flush=1 with in_valid=1 for one cycle -> next cycle out_valid=0, in_ready=1, flushed words and the offered word never appear.
REQ-039 Preload xfer_cnt to 16'hFFFE by 65534 transfers (or forced), two more transfers -> xfer_cnt=16'h0000; rst_n=0 mid-stream for one cycle -> all outputs 0 next cycle, xfer_cnt=0.
REQ-040 STAGES=0, MODE=7 -> out_data=0 for any in_data; in_ready tracks out_ready combinationally.
